// File: rtl/branch_predictor_if.sv
// branch_predictor_if
//   Bundles the fetch-side prediction port and the execute-side resolution
//   port of the branch predictor.
//   master : pipeline side, drives if_pc and the upd_* resolution fields,
//            receives the prediction, mispredict flag and statistics.
//   slave  : predictor side, the mirror image.
//   Signals:
//     if_pc            fetch PC to predict
//     pred_taken       predicted direction for if_pc
//     pred_target      predicted next PC for if_pc
//     upd_valid        a conditional branch resolved this cycle
//     upd_pc           PC of the resolved branch
//     upd_taken        actual outcome
//     upd_target       actual target
//     upd_pred_taken   direction that was predicted for it
//     upd_pred_target  target that was predicted for it
//     mispredict       resolved branch was mispredicted
//     br_count         resolved branches (saturating)
//     miss_count       mispredictions (saturating)
interface branch_predictor_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] br_count;
  logic [31:0] miss_count;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, mispredict, br_count, miss_count
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, mispredict, br_count, miss_count
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor
//   Dynamic branch predictor for the fetch stage: a direct-mapped table of
//   2-bit saturating counters plus a tagged branch target buffer, trained by
//   the execute-stage branch resolution. Prediction and mispredict detection
//   are combinational; training happens on the rising clock edge.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset (counters to CNT_INIT, BTB
//          invalidated, statistics cleared)
//     bp   branch_predictor_if.slave (prediction, resolution, statistics)
module branch_predictor #(
  parameter int         IDX_BITS = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic                clk,
  input  logic                rst,
  branch_predictor_if.slave   bp
);
  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = 30 - IDX_BITS;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cntState_t;

  // Index/tag split of both PCs; bits [1:0] never participate.
  logic [IDX_BITS-1:0] ifIdx, updIdx;
  logic [TAG_BITS-1:0] ifTag, updTag;
  logic [1:0]          unusedPcLsb;

  assign ifIdx       = bp.if_pc[IDX_BITS+1:2];
  assign ifTag       = bp.if_pc[31:IDX_BITS+2];
  assign updIdx      = bp.upd_pc[IDX_BITS+1:2];
  assign updTag      = bp.upd_pc[31:IDX_BITS+2];
  assign unusedPcLsb = bp.upd_pc[1:0];

  // Flattened views of the per-entry state so both ports can index them.
  logic [2*ENTRIES-1:0] cntVec;
  logic [ENTRIES-1:0]   validVec;

  // Per-entry counter FSM and BTB valid bit. These need the asynchronous
  // reset, so they live in flops rather than a RAM.
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      cntState_t stateReg, stateNext;
      logic      validReg;
      logic      hitUpd;

      assign hitUpd = bp.upd_valid && (updIdx == IDX_BITS'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stateReg <= cntState_t'(CNT_INIT);
        end else begin
          stateReg <= stateNext;
        end
      end

      // Taken moves toward ST, not-taken toward SNT; the ends hold.
      always_comb begin
        stateNext = stateReg;
        if (hitUpd) begin
          case (stateReg)
            SNT:     stateNext = bp.upd_taken ? WNT : SNT;
            WNT:     stateNext = bp.upd_taken ? WT  : SNT;
            WT:      stateNext = bp.upd_taken ? ST  : WNT;
            ST:      stateNext = bp.upd_taken ? ST  : WT;
            default: stateNext = cntState_t'(CNT_INIT);
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          validReg <= 1'b0;
        end else if (hitUpd && bp.upd_taken) begin
          validReg <= 1'b1;
        end
      end

      assign cntVec[2*gi +: 2] = stateReg;
      assign validVec[gi]      = validReg;
    end
  endgenerate

  // Tag and target storage. Contents are meaningless while the matching
  // valid bit is clear, so no reset is needed here.
  logic [TAG_BITS-1:0] btbTag    [ENTRIES];
  logic [31:0]         btbTarget [ENTRIES];

  always_ff @(posedge clk) begin
    if (!rst && bp.upd_valid && bp.upd_taken) begin
      btbTag[updIdx]    <= updTag;
      btbTarget[updIdx] <= bp.upd_target;
    end
  end

  // Prediction reads the pre-update state: a same-cycle write to the same
  // index is only seen from the next cycle.
  logic        ifHit;
  logic [1:0]  ifCnt;
  logic        predTakenNext;

  assign ifCnt         = cntVec[2*ifIdx +: 2];
  assign ifHit         = validVec[ifIdx] && (btbTag[ifIdx] == ifTag);
  assign predTakenNext = ifHit && ifCnt[1];

  assign bp.pred_taken  = predTakenNext;
  assign bp.pred_target = predTakenNext ? btbTarget[ifIdx] : (bp.if_pc + 32'd4);

  // A wrong direction, or a correct taken prediction to the wrong target.
  logic mispredictNext;

  assign mispredictNext = bp.upd_valid &&
                          ((bp.upd_taken != bp.upd_pred_taken) ||
                           (bp.upd_taken && bp.upd_pred_taken &&
                            (bp.upd_target != bp.upd_pred_target)));

  assign bp.mispredict = mispredictNext;

  // Statistics, both saturating at all-ones.
  logic [31:0] brCountReg, missCountReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brCountReg   <= 32'd0;
      missCountReg <= 32'd0;
    end else if (bp.upd_valid) begin
      if (brCountReg != 32'hFFFF_FFFF) begin
        brCountReg <= brCountReg + 32'd1;
      end
      if (mispredictNext && (missCountReg != 32'hFFFF_FFFF)) begin
        missCountReg <= missCountReg + 32'd1;
      end
    end
  end

  assign bp.br_count   = brCountReg;
  assign bp.miss_count = missCountReg;
endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
  logic clk;
  logic rst;

  branch_predictor_if bpIf ();

  branch_predictor #(.IDX_BITS(6), .CNT_INIT(2'b01)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bpIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model of the predictor state (IDX_BITS = 6).
  logic [1:0]  mCnt    [64];
  logic        mValid  [64];
  logic [23:0] mTag    [64];
  logic [31:0] mTarget [64];
  logic [31:0] mBr, mMiss;

  typedef struct {
    logic        taken;
    logic [31:0] target;
  } pred_t;

  typedef struct {
    logic [31:0] br;
    logic [31:0] miss;
  } stats_t;

  pred_t  predQ  [$];
  logic   mpQ    [$];
  stats_t statsQ [$];

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      mCnt[i]   = 2'b01;
      mValid[i] = 1'b0;
    end
    mBr   = 32'd0;
    mMiss = 32'd0;
  endfunction

  function automatic pred_t model_pred(input logic [31:0] pc);
    pred_t p;
    logic [5:0] i;
    i = pc[7:2];
    p.taken  = mValid[i] && (mTag[i] == pc[31:8]) && mCnt[i][1];
    p.target = p.taken ? mTarget[i] : pc + 32'd4;
    return p;
  endfunction

  function automatic logic model_miss(input logic v, input logic t, input logic [31:0] tg,
                                      input logic pt, input logic [31:0] ptg);
    return v && ((t != pt) || (t && pt && (tg != ptg)));
  endfunction

  function automatic stats_t model_stats();
    stats_t s;
    s.br   = mBr;
    s.miss = mMiss;
    return s;
  endfunction

  // Drives one resolution (or an idle cycle when v = 0) plus a fetch PC at
  // the current point (caller is at a negedge) and queues the expected
  // combinational outputs for this cycle.
  task automatic drive(input logic [31:0] ifpc, input logic v, input logic [31:0] pc,
                       input logic t, input logic [31:0] tg, input logic pt,
                       input logic [31:0] ptg);
    bpIf.if_pc           = ifpc;
    bpIf.upd_valid       = v;
    bpIf.upd_pc          = pc;
    bpIf.upd_taken       = t;
    bpIf.upd_target      = tg;
    bpIf.upd_pred_taken  = pt;
    bpIf.upd_pred_target = ptg;
    predQ.push_back(model_pred(ifpc));
    mpQ.push_back(model_miss(v, t, tg, pt, ptg));
  endtask

  // Advances one clock, applies the training to the model and queues the
  // expected statistics.
  task automatic commit();
    logic [5:0] i;
    @(posedge clk);
    if (bpIf.upd_valid) begin
      i = bpIf.upd_pc[7:2];
      if (bpIf.upd_taken) begin
        if (mCnt[i] != 2'b11) mCnt[i] = mCnt[i] + 2'b01;
        mValid[i]  = 1'b1;
        mTag[i]    = bpIf.upd_pc[31:8];
        mTarget[i] = bpIf.upd_target;
      end else begin
        if (mCnt[i] != 2'b00) mCnt[i] = mCnt[i] - 2'b01;
      end
      if (mBr != 32'hFFFF_FFFF) mBr = mBr + 32'd1;
      if (model_miss(1'b1, bpIf.upd_taken, bpIf.upd_target, bpIf.upd_pred_taken,
                     bpIf.upd_pred_target) && (mMiss != 32'hFFFF_FFFF))
        mMiss = mMiss + 32'd1;
    end
    statsQ.push_back(model_stats());
    #1;
    bpIf.upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    model_reset();
    #1;
    begin
      pred_t p;
      logic  m;
      p = predQ.pop_front();
      m = mpQ.pop_front();
      checks++;
      if (bpIf.pred_taken !== 1'b0 || p.taken !== 1'b0) begin
        errors++; $display("FAIL reset_pred_taken: got %b expected 0", bpIf.pred_taken);
      end
      checks++;
      if (bpIf.pred_target !== 32'h104) begin
        errors++; $display("FAIL reset_pred_target: got %h expected 00000104", bpIf.pred_target);
      end
      checks++;
      if (bpIf.mispredict !== m) begin
        errors++; $display("FAIL reset_mispredict: got %b expected %b", bpIf.mispredict, m);
      end
      checks++;
      if (bpIf.br_count !== 32'd0 || bpIf.miss_count !== 32'd0) begin
        errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0",
                           bpIf.br_count, bpIf.miss_count);
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_train();
    pred_t  p;
    stats_t s;
    logic   m;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
      #1;
      m = mpQ.pop_front();
      void'(predQ.pop_front());
      checks++;
      if (bpIf.mispredict !== m || m !== 1'b1) begin
        errors++; $display("FAIL train_mispredict[%0d]: got %b expected 1", k, bpIf.mispredict);
      end
      commit();
      s = statsQ.pop_front();
    end
    @(negedge clk);
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    p = predQ.pop_front();
    void'(mpQ.pop_front());
    checks++;
    if (bpIf.pred_taken !== p.taken || bpIf.pred_target !== p.target ||
        bpIf.pred_target !== 32'h200 || bpIf.pred_taken !== 1'b1) begin
      errors++; $display("FAIL train_pred: got %b/%h expected 1/00000200",
                         bpIf.pred_taken, bpIf.pred_target);
    end
    checks++;
    if (bpIf.br_count !== s.br || bpIf.miss_count !== s.miss ||
        bpIf.br_count !== 32'd2 || bpIf.miss_count !== 32'd2) begin
      errors++; $display("FAIL train_stats: got %0d/%0d expected 2/2",
                         bpIf.br_count, bpIf.miss_count);
    end
  endtask

  task automatic test_saturation();
    pred_t p;
    logic  m;
    logic  expTaken [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic  outcome  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(32'h100, 1'b1, 32'h100, outcome[k], 32'h200, 1'b1, 32'h200);
      #1;
      p = predQ.pop_front();
      m = mpQ.pop_front();
      checks++;
      if (bpIf.pred_taken !== p.taken || bpIf.pred_taken !== expTaken[k]) begin
        errors++; $display("FAIL sat_pred[%0d]: got %b expected %b", k, bpIf.pred_taken, p.taken);
      end
      checks++;
      if (bpIf.mispredict !== m) begin
        errors++; $display("FAIL sat_mispredict[%0d]: got %b expected %b", k, bpIf.mispredict, m);
      end
      commit();
      void'(statsQ.pop_front());
    end
    // ST -> WT -> WNT: the second not-taken drops the prediction.
    @(negedge clk);
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    p = predQ.pop_front();
    void'(mpQ.pop_front());
    checks++;
    if (bpIf.pred_taken !== p.taken || bpIf.pred_taken !== expTaken[5] ||
        bpIf.pred_target !== 32'h104) begin
      errors++; $display("FAIL sat_final: got %b/%h expected 0/00000104",
                         bpIf.pred_taken, bpIf.pred_target);
    end
  endtask

  task automatic test_target_mismatch();
    pred_t p;
    logic  m;
    @(negedge clk);
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
    #1;
    m = mpQ.pop_front();
    void'(predQ.pop_front());
    checks++;
    if (bpIf.mispredict !== m || m !== 1'b1) begin
      errors++; $display("FAIL tgt_mispredict: got %b expected 1", bpIf.mispredict);
    end
    commit();
    void'(statsQ.pop_front());
    @(negedge clk);
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    p = predQ.pop_front();
    void'(mpQ.pop_front());
    checks++;
    if (bpIf.pred_taken !== p.taken || bpIf.pred_target !== p.target ||
        bpIf.pred_target !== 32'h300) begin
      errors++; $display("FAIL tgt_pred: got %b/%h expected 1/00000300",
                         bpIf.pred_taken, bpIf.pred_target);
    end
  endtask

  task automatic test_alias_and_wrap();
    pred_t p;
    logic [31:0] pcs  [2] = '{32'h200, 32'hFFFF_FFFC};
    logic [31:0] tgts [2] = '{32'h204, 32'h0000_0000};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(pcs[k], 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      p = predQ.pop_front();
      void'(mpQ.pop_front());
      checks++;
      if (bpIf.pred_taken !== p.taken || bpIf.pred_target !== p.target ||
          bpIf.pred_taken !== 1'b0 || bpIf.pred_target !== tgts[k]) begin
        errors++; $display("FAIL alias_wrap[%0d]: got %b/%h expected 0/%h",
                           k, bpIf.pred_taken, bpIf.pred_target, tgts[k]);
      end
    end
  endtask

  task automatic test_same_cycle();
    pred_t p;
    // Bring 0x100 down to WNT, then train taken while fetching 0x100.
    @(negedge clk);
    drive(32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h300);
    commit();
    void'(predQ.pop_front()); void'(mpQ.pop_front()); void'(statsQ.pop_front());
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(32'h100, (k == 0), 32'h100, 1'b1, 32'h300, 1'b0, 32'h0);
      #1;
      p = predQ.pop_front();
      void'(mpQ.pop_front());
      checks++;
      if (bpIf.pred_taken !== p.taken || bpIf.pred_target !== p.target ||
          bpIf.pred_taken !== (k == 1)) begin
        errors++; $display("FAIL same_cycle[%0d]: got %b/%h expected %b/%h",
                           k, bpIf.pred_taken, bpIf.pred_target, p.taken, p.target);
      end
      commit();
      void'(statsQ.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    pred_t       p;
    stats_t      s;
    logic        m;
    logic [31:0] pool [6] = '{32'h100, 32'h200, 32'h103, 32'h140, 32'h1000, 32'h144};
    logic [31:0] ifpc, upc, tg, ptg;
    logic        v, t, pt;
    for (int k = 0; k < 40; k++) begin
      ifpc = pool[$urandom_range(0, 5)];
      upc  = pool[$urandom_range(0, 5)];
      v    = ($urandom_range(0, 3) != 0);
      t    = $urandom_range(0, 1);
      pt   = $urandom_range(0, 1);
      tg   = 32'h400 + 32'($urandom_range(0, 3)) * 32'h10;
      ptg  = 32'h400 + 32'($urandom_range(0, 3)) * 32'h10;
      @(negedge clk);
      drive(ifpc, v, upc, t, tg, pt, ptg);
      #1;
      p = predQ.pop_front();
      m = mpQ.pop_front();
      checks++;
      if (bpIf.pred_taken !== p.taken || bpIf.pred_target !== p.target) begin
        errors++; $display("FAIL b2b_pred[%0d]: pc %h got %b/%h expected %b/%h", k, ifpc,
                           bpIf.pred_taken, bpIf.pred_target, p.taken, p.target);
      end
      checks++;
      if (bpIf.mispredict !== m) begin
        errors++; $display("FAIL b2b_mispredict[%0d]: got %b expected %b", k, bpIf.mispredict, m);
      end
      commit();
      s = statsQ.pop_front();
      checks++;
      if (bpIf.br_count !== s.br || bpIf.miss_count !== s.miss) begin
        errors++; $display("FAIL b2b_stats[%0d]: got %0d/%0d expected %0d/%0d", k,
                           bpIf.br_count, bpIf.miss_count, s.br, s.miss);
      end
    end
  endtask

  task automatic test_async_reset();
    pred_t p;
    // Make sure 0x100 predicts taken beforehand.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      commit();
      void'(predQ.pop_front()); void'(mpQ.pop_front()); void'(statsQ.pop_front());
    end
    @(negedge clk);
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    void'(predQ.pop_front());
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    p = model_pred(32'h100);
    checks++;
    if (bpIf.pred_taken !== p.taken || bpIf.pred_target !== p.target ||
        bpIf.pred_target !== 32'h104) begin
      errors++; $display("FAIL async_pred: got %b/%h expected 0/00000104",
                         bpIf.pred_taken, bpIf.pred_target);
    end
    checks++;
    if (bpIf.br_count !== 32'd0 || bpIf.miss_count !== 32'd0) begin
      errors++; $display("FAIL async_stats: got %0d/%0d expected 0/0",
                         bpIf.br_count, bpIf.miss_count);
    end
    checks++;
    if (bpIf.mispredict !== mpQ.pop_front()) begin
      errors++; $display("FAIL async_mispredict: got %b expected 1", bpIf.mispredict);
    end
    bpIf.upd_valid = 1'b0;
    #1;
    rst = 1'b0;
    commit();
    s_check: begin
      stats_t s;
      s = statsQ.pop_front();
      checks++;
      if (bpIf.br_count !== s.br || bpIf.pred_taken !== 1'b0) begin
        errors++; $display("FAIL async_after: got %0d/%b expected %0d/0",
                           bpIf.br_count, bpIf.pred_taken, s.br);
      end
    end
  endtask

  initial begin
    bpIf.if_pc = 32'h0;
    bpIf.upd_valid = 1'b0;
    bpIf.upd_pc = 32'h0;
    bpIf.upd_taken = 1'b0;
    bpIf.upd_target = 32'h0;
    bpIf.upd_pred_taken = 1'b0;
    bpIf.upd_pred_target = 32'h0;
    test_reset();
    test_train();
    test_saturation();
    test_target_mismatch();
    test_alias_and_wrap();
    test_same_cycle();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
